// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
// Imported by the arbiter top and its grant decoder.
package rr_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter_8_decoder_3to8.sv
// 3-to-8 one-hot decoder with enable, used for the arbiter grant.
// Ports: en_i enable, idx_i index, onehot_o decoded vector (0 when disabled).
module decoder_3to8
  import rr_arbiter_8_pkg::*;
(
  input  logic               en_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one DATA_W transfer port among 8 requesters.
// Ports: iClk/iRstn, iReq/iLock/iData per requester, iReady from downstream;
// oValid/oData shared port, oGnt/oGntIdx grant, oAck per-requester completion.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic                        iClk,
  input  logic                        iRstn,
  input  logic [NUM_REQ-1:0]          iReq,
  input  logic [NUM_REQ-1:0]          iLock,
  input  logic [NUM_REQ*DATA_W-1:0]   iData,
  input  logic                        iReady,
  output logic                        oValid,
  output logic [DATA_W-1:0]           oData,
  output logic [NUM_REQ-1:0]          oGnt,
  output logic [IDX_W-1:0]            oGntIdx,
  output logic [NUM_REQ-1:0]          oAck
);

  // At least one bit so MAX_HOLD=1 still has a legal counter.
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                busy;
  logic [NUM_REQ-1:0]  gnt;
  logic                valid;
  logic                xfer;
  logic                keep;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0]  rem;
  logic [DATA_W-1:0]   data_sel;

  // First set bit of vec, scanning upward from ptr with wrap.
  function automatic logic [IDX_W-1:0] pick(
    input logic [NUM_REQ-1:0] vec,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign busy = (state_q == BUSY);

  decoder_3to8 u_dec (
    .en_i     (busy),
    .idx_i    (idx_q),
    .onehot_o (gnt)
  );

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_q == IDX_W'(k)) begin
        data_sel = iData[k*DATA_W +: DATA_W];
      end
    end
  end

  assign valid   = busy & iReq[idx_q];
  assign xfer    = valid & iReady;
  assign keep    = iLock[idx_q] && (hold_q < HOLD_LAST);
  assign ptr_nxt = idx_q + IDX_W'(1);
  // Current winner is masked so a forced release cannot re-grant it.
  assign rem     = iReq & ~gnt;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|iReq) begin
          state_d = BUSY;
          idx_d   = pick(iReq, ptr_q);
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (!iReq[idx_q]) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (iReady) begin
          if (keep) begin
            hold_d = hold_q + HOLD_W'(1);
          end else begin
            ptr_d  = ptr_nxt;
            hold_d = '0;
            if (|rem) begin
              idx_d = pick(rem, ptr_nxt);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign oValid  = valid;
  assign oData   = valid ? data_sel : '0;
  assign oGnt    = gnt;
  assign oGntIdx = idx_q;
  assign oAck    = xfer ? gnt : '0;

endmodule
